// File: rtl/display_buffer_ctrl.sv
// Character display buffer: cursor-driven writes from the processor,
// clear/scroll sweeps, and a registered read port for the draw unit.
module display_buffer_ctrl #(
  parameter int CHARS_HORZ = 80,
  parameter int CHARS_VERT = 30,
  parameter int ASCII_SIZE = 8
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic                          wr_valid,
  input  logic [ASCII_SIZE-1:0]         wr_char,
  output logic                          wr_ready,
  output logic                          busy,
  output logic [$clog2(CHARS_VERT)-1:0] cur_row,
  output logic [$clog2(CHARS_HORZ)-1:0] cur_col,
  input  logic [$clog2(CHARS_VERT)-1:0] rd_row,
  input  logic [$clog2(CHARS_HORZ)-1:0] rd_col,
  output logic [ASCII_SIZE-1:0]         rd_char
);

  localparam int N     = CHARS_VERT;
  localparam int H     = CHARS_HORZ;
  localparam int CELLS = N * H;
  localparam int RW    = $clog2(N);
  localparam int CW    = $clog2(H);
  localparam int AW    = $clog2(CELLS);
  localparam int IW    = AW + 1;

  localparam logic [IW-1:0] LAST    = IW'(CELLS - 1);
  localparam logic [IW-1:0] SCR_END = IW'((N - 1) * H);
  localparam logic [IW-1:0] HSTEP   = IW'(H);

  localparam logic [ASCII_SIZE-1:0] C_SP = ASCII_SIZE'(32);
  localparam logic [ASCII_SIZE-1:0] C_TL = ASCII_SIZE'(126);
  localparam logic [ASCII_SIZE-1:0] C_LF = ASCII_SIZE'(10);
  localparam logic [ASCII_SIZE-1:0] C_CR = ASCII_SIZE'(13);
  localparam logic [ASCII_SIZE-1:0] C_BS = ASCII_SIZE'(8);
  localparam logic [ASCII_SIZE-1:0] C_FF = ASCII_SIZE'(12);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SCROLL
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nx;
  logic [RW-1:0] r_row;
  logic [RW-1:0] w_row_nx;
  logic [CW-1:0] r_col;
  logic [CW-1:0] w_col_nx;

  logic                  w_we;
  logic [AW-1:0]         w_waddr;
  logic [ASCII_SIZE-1:0] w_wdata;
  logic                  w_adv;

  logic [ASCII_SIZE-1:0] r_buf [CELLS];
  logic [ASCII_SIZE-1:0] r_rd;

  logic [AW-1:0] w_cur_idx;
  logic [AW-1:0] w_src_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_rd_ok;
  logic          w_print;

  assign w_cur_idx = AW'(r_row) * AW'(H) + AW'(r_col);
  // Source pointer clamped so the array is never indexed past its end.
  assign w_src_idx = (r_idx < SCR_END) ? AW'(r_idx + HSTEP) : AW'(r_idx);
  assign w_rd_idx  = AW'(rd_row) * AW'(H) + AW'(rd_col);
  assign w_rd_ok   = (int'(rd_row) < N) && (int'(rd_col) < H);
  assign w_print   = (wr_char >= C_SP) && (wr_char <= C_TL);

  assign wr_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign cur_row  = r_row;
  assign cur_col  = r_col;
  assign rd_char  = r_rd;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_row   <= w_row_nx;
      r_col   <= w_col_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_row_nx   = r_row;
    w_col_nx   = r_col;
    w_we       = 1'b0;
    w_waddr    = AW'(r_idx);
    w_wdata    = C_SP;
    w_adv      = 1'b0;

    unique case (r_state)
      S_CLEAR: begin
        w_we = 1'b1;
        if (r_idx == LAST) begin
          w_state_nx = S_IDLE;
          w_idx_nx   = '0;
          w_row_nx   = '0;
          w_col_nx   = '0;
        end else begin
          w_idx_nx = r_idx + IW'(1);
        end
      end
      S_SCROLL: begin
        w_we = 1'b1;
        if (r_idx < SCR_END) begin
          w_wdata = r_buf[w_src_idx];
        end
        if (r_idx == LAST) begin
          w_state_nx = S_IDLE;
          w_idx_nx   = '0;
        end else begin
          w_idx_nx = r_idx + IW'(1);
        end
      end
      S_IDLE: begin
        if (wr_valid) begin
          unique case (1'b1)
            w_print: begin
              w_we    = 1'b1;
              w_waddr = w_cur_idx;
              w_wdata = wr_char;
              if (r_col == CW'(H - 1)) begin
                w_col_nx = '0;
                w_adv    = 1'b1;
              end else begin
                w_col_nx = r_col + CW'(1);
              end
            end
            (wr_char == C_LF): begin
              w_col_nx = '0;
              w_adv    = 1'b1;
            end
            (wr_char == C_CR): begin
              w_col_nx = '0;
            end
            (wr_char == C_BS): begin
              if (r_col != '0) begin
                w_col_nx = r_col - CW'(1);
                w_we     = 1'b1;
                w_waddr  = w_cur_idx - AW'(1);
              end
            end
            (wr_char == C_FF): begin
              w_state_nx = S_CLEAR;
              w_idx_nx   = '0;
            end
            default: begin
            end
          endcase
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // Falling off the last row parks the cursor and starts a scroll.
    if (w_adv) begin
      if (r_row == RW'(N - 1)) begin
        w_col_nx   = '0;
        w_state_nx = S_SCROLL;
        w_idx_nx   = '0;
      end else begin
        w_row_nx = r_row + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_buf[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_rd <= C_SP;
    end else begin
      r_rd <= w_rd_ok ? r_buf[w_rd_idx] : C_SP;
    end
  end

endmodule

// File: tb/tb_display_buffer_ctrl.sv
// Bench for display_buffer_ctrl: directed scenarios plus random byte
// stream, checked every cycle against a cell-array model.
module tb_display_buffer_ctrl;

  localparam int N     = 30;
  localparam int H     = 80;
  localparam int CELLS = N * H;

  logic       clk      = 1'b0;
  logic       RESET    = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_char  = 8'h00;
  logic       wr_ready;
  logic       busy;
  logic [4:0] cur_row;
  logic [6:0] cur_col;
  logic [4:0] rd_row   = 5'd0;
  logic [6:0] rd_col   = 7'd0;
  logic [7:0] rd_char;

  display_buffer_ctrl dut (
    .clk      (clk),
    .RESET    (RESET),
    .wr_valid (wr_valid),
    .wr_char  (wr_char),
    .wr_ready (wr_ready),
    .busy     (busy),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_char  (rd_char)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int last_wait = 0;

  // Model: screen as a 2D array, sweeps applied at once, busy as a countdown
  logic [7:0] m_buf [N][H];
  int         m_row  = 0;
  int         m_col  = 0;
  int         m_busy = CELLS;
  logic [7:0] e_rd   = 8'h20;
  bit         e_rd_ok = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic m_blank();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < H; c++)
        m_buf[r][c] = 8'h20;
  endtask

  task automatic m_adv();
    if (m_row < N - 1) begin
      m_row++;
    end else begin
      for (int r = 0; r < N - 1; r++)
        for (int c = 0; c < H; c++)
          m_buf[r][c] = m_buf[r+1][c];
      for (int c = 0; c < H; c++)
        m_buf[N-1][c] = 8'h20;
      m_col  = 0;
      m_busy = CELLS;
    end
  endtask

  task automatic m_accept(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      m_buf[m_row][m_col] = c;
      if (m_col == H - 1) begin
        m_col = 0;
        m_adv();
      end else begin
        m_col++;
      end
    end else if (c == 8'h0A) begin
      m_col = 0;
      m_adv();
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_buf[m_row][m_col] = 8'h20;
      end
    end else if (c == 8'h0C) begin
      m_blank();
      m_row  = 0;
      m_col  = 0;
      m_busy = CELLS;
    end
  endtask

  always @(posedge clk) begin
    if (RESET) begin
      m_blank();
      m_row   = 0;
      m_col   = 0;
      m_busy  = CELLS;
      e_rd    = 8'h20;
      e_rd_ok = 1'b1;
    end else begin
      e_rd_ok = (m_busy == 0);
      e_rd = (rd_row < N && rd_col < H) ? m_buf[rd_row][rd_col] : 8'h20;
      if (m_busy > 0) m_busy--;
      else if (wr_valid) m_accept(wr_char);
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_busy > 0);
    chk("wr_ready", wr_ready, m_busy == 0);
    if (e_rd_ok) chk("rd_char", rd_char, e_rd);
    if (m_busy == 0) begin
      chk("cur_row", cur_row, m_row);
      chk("cur_col", cur_col, m_col);
    end
  end

  task automatic send(input logic [7:0] c);
    int n = 0;
    wr_valid = 1'b1;
    wr_char  = c;
    while (!wr_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    chk("send_ready", wr_ready, 1);
    if (wr_ready) @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic busy_len(input string nm);
    int n = 0;
    while (busy && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, n, CELLS);
    @(negedge clk);
  endtask

  task automatic chk_cell(input string nm, input int r, input int c,
                          input logic [7:0] exp);
    rd_row = 5'(r);
    rd_col = 7'(c);
    @(negedge clk);
    chk(nm, rd_char, exp);
  endtask

  function automatic logic [7:0] rnd_code();
    int r = $urandom_range(0, 999);
    if (r < 700) return 8'($urandom_range(32, 126));
    if (r < 730) return 8'h0A;
    if (r < 780) return 8'h0D;
    if (r < 880) return 8'h08;
    if (r < 884) return 8'h0C;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #2 RESET = 1'b0;
    busy_len("reset_busy_len");
    chk("reset_row", cur_row, 0);
    chk("reset_col", cur_col, 0);
    chk_cell("reset_c0", 0, 0, 8'h20);
    chk_cell("reset_clast", 29, 79, 8'h20);
    chk_cell("reset_cmid", 15, 40, 8'h20);
    chk_cell("oob_row", 31, 3, 8'h20);
    chk_cell("oob_col", 2, 100, 8'h20);

    send(8'h41);
    send(8'h42);
    chk_cell("ab_c0", 0, 0, 8'h41);
    chk_cell("ab_c1", 0, 1, 8'h42);
    chk("ab_col", cur_col, 2);
    chk("model_ab_col", m_col, 2);

    rd_row = 5'd0;
    rd_col = 7'd2;
    send(8'h43);
    chk("same_cycle_old", rd_char, 8'h20);
    @(negedge clk);
    chk("next_cycle_new", rd_char, 8'h43);

    send(8'h0D);
    chk("cr_col", cur_col, 0);
    repeat (H) send(8'h41);
    chk("wrap_row", cur_row, 1);
    chk("wrap_col", cur_col, 0);
    chk("model_wrap_row", m_row, 1);
    send(8'h08);
    chk("bs0_row", cur_row, 1);
    chk("bs0_col", cur_col, 0);

    send(8'h0C);
    busy_len("ff_busy_len");
    send(8'h48); send(8'h45); send(8'h4C); send(8'h4C); send(8'h4F);
    chk("hello_col", cur_col, 5);
    send(8'h08);
    chk("bs_col", cur_col, 4);
    chk_cell("bs_cell", 0, 4, 8'h20);
    chk_cell("bs_keep", 0, 3, 8'h4C);

    repeat (N - 1) send(8'h0A);
    chk("lf_row", cur_row, 29);
    chk("lf_col", cur_col, 0);
    repeat (H) send(8'h5A);
    busy_len("scroll_busy_len");
    chk("scroll_row", cur_row, 29);
    chk("scroll_col", cur_col, 0);
    for (int c = 0; c < H; c++) begin
      chk_cell("row28_z", 28, c, 8'h5A);
      chk_cell("row29_blank", 29, c, 8'h20);
    end

    send(8'h0A);
    send(8'h41);
    chk("bp_wait", last_wait, CELLS);
    chk_cell("bp_cell", 29, 0, 8'h41);
    chk_cell("bp_row27", 27, 5, 8'h5A);
    chk_cell("bp_row28", 28, 5, 8'h20);
    chk("bp_col", cur_col, 1);

    send(8'h0C);
    repeat (100) @(negedge clk);
    #2 RESET = 1'b1;
    repeat (3) @(negedge clk);
    #2 RESET = 1'b0;
    busy_len("midrst_busy_len");
    chk("midrst_row", cur_row, 0);
    chk("midrst_col", cur_col, 0);
    chk_cell("midrst_cell", 29, 0, 8'h20);

    for (int i = 0; i < 1500; i++) begin
      rd_row = 5'($urandom_range(0, 31));
      rd_col = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      else send(rnd_code());
    end
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("final_idle", busy, 0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
